spike_gen_array: RTL and testbench
==================================

SPIKE_GEN_ARRAY -- requirements
Module: spike_gen_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent neuron channels; must be 2 or more.
REQ-002 SHALL have parameter SUM_WIDTH, default 16: width of the signed input partial sum.
REQ-003 SHALL have parameter POT_WIDTH, default 16: width of the signed per-channel potential; must be SUM_WIDTH or more.
REQ-004 SHALL have parameter REFRAC_WIDTH, default 4: width of the per-channel refractory counter.
REQ-005 SHALL derive CH_W = $clog2(NUM_CH) as a localparam.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port spike_en, input, 1 bit: global enable for accepting sums.
REQ-009 SHALL have port clear_all, input, 1 bit: synchronous pulse that zeroes all potentials and refractory counters.
REQ-010 SHALL have port in_valid, input, 1 bit: in_sum/in_ch are valid.
REQ-011 SHALL have port in_ready, output, 1 bit: block can accept this cycle.
REQ-012 SHALL have port in_ch, input, CH_W bits: target channel.
REQ-013 SHALL have port in_sum, input, SUM_WIDTH bits: signed partial sum.
REQ-014 SHALL have port threshold, input, POT_WIDTH-1 bits: unsigned firing threshold, shared by all channels.
REQ-015 SHALL have port reset_mode, input, 1 bit: 0 = subtract threshold on spike, 1 = reset to zero on spike.
REQ-016 SHALL have port refrac_period, input, REFRAC_WIDTH bits: cycles of accepted inputs ignored after a spike.
REQ-017 SHALL have port out_valid, output, 1 bit: registered result strobe.
REQ-018 SHALL have port out_ch, output, CH_W bits: channel of the result.
REQ-019 SHALL have port out_spike, output, 1 bit: 1 = channel fired.

Function
REQ-020 SHALL drive in_ready = spike_en & ~clear_all; accept = in_valid & in_ready.
REQ-021 SHALL, on accept, assert out_valid exactly one cycle later with out_ch = in_ch; out_valid SHALL be 0 in every cycle that does not follow an accept.
REQ-022 SHALL form S = potential[in_ch] + sign-extended in_sum, saturating to [-2^(POT_WIDTH-1), 2^(POT_WIDTH-1)-1].
REQ-023 SHALL, if refrac[in_ch] != 0: decrement refrac[in_ch] by 1; leave the potential unchanged; set out_spike = 0.
REQ-024 SHALL, otherwise, if S >= threshold (signed compare, threshold zero-extended): set out_spike = 1 and refrac[in_ch] = refrac_period; set potential to S - threshold if reset_mode = 0, or to 0 if reset_mode = 1.
REQ-025 SHALL, otherwise: set potential = S (leak per REQ-031) and out_spike = 0.
REQ-026 SHALL leave channels other than in_ch unchanged.
REQ-027 SHALL give back-to-back accepts on the same channel full throughput (no bubble): the second accept uses the potential written by the first.
REQ-028 SHALL make clear_all take priority over any input: it zeroes all state that cycle, the input is not accepted, and out_valid is 0 the next cycle.
REQ-029 SHALL treat refrac_period = 0 as no refractory period.
REQ-030 SHALL sample threshold, reset_mode and refrac_period at accept; changing them mid-stream affects only later accepts.

Reset
REQ-031 (moved: see Configuration.)
REQ-032 SHALL, while rst = 1, asynchronously force: all potentials = 0, all refrac = 0, out_valid = 0, out_spike = 0, out_ch = 0.
REQ-033 SHALL discard an accept in flight when rst asserts mid-operation; no out_valid SHALL follow the release of reset.

Configuration
REQ-031 SHALL, with macro SPIKE_GEN_LEAK_EN defined, add input leak (POT_WIDTH-1 bits, unsigned).
- In the non-firing case, move potential toward 0 by leak, clamped at 0 without crossing it.
- Without the macro: no leak port and no leak logic.

Verification
REQ-034 SHALL verify: threshold=100, reset_mode=0, ch1 sums 60,60 -> out_spike 0 then 1; potential[ch1]=20; other channels remain 0.
REQ-035 SHALL verify: reset_mode=1, threshold=50, ch0 sum 70 -> out_spike=1; potential[ch0]=0.
REQ-036 SHALL verify: refrac_period=2, ch2 fires, then 3 sums of 200 -> spikes 0,0,1.
REQ-037 SHALL verify: potential 32000, sum 32000 -> S saturates to 32767; with threshold 32767, out_spike=1.
REQ-038 SHALL verify: clear_all and in_valid in the same cycle -> in_ready=0, no out_valid, all potentials 0.
REQ-039 SHALL verify: with SPIKE_GEN_LEAK_EN, leak=5, potential -3, sum 0 -> potential 0; rst mid-stream -> out_valid 0.

Source files
------------

// File: rtl/spike_gen_array.sv
// Multi-channel integrate-and-fire spike generator; optional leak under SPIKE_GEN_LEAK_EN.
// Latency: one cycle from accept to out_valid; back-to-back accepts on one channel are bubble-free.
// Backpressure: in_ready drops when spike_en is low or clear_all is pulsed.
module spike_gen_array #(
    parameter int NUM_CH       = 4,
    parameter int SUM_WIDTH    = 16,
    parameter int POT_WIDTH    = 16,
    parameter int REFRAC_WIDTH = 4,
    localparam int CH_W        = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spike_en,
    input  logic                    clear_all,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_W-1:0]         in_ch,
    input  logic [SUM_WIDTH-1:0]    in_sum,
    input  logic [POT_WIDTH-2:0]    threshold,
    input  logic                    reset_mode,
    input  logic [REFRAC_WIDTH-1:0] refrac_period,
`ifdef SPIKE_GEN_LEAK_EN
    input  logic [POT_WIDTH-2:0]    leak,
`endif
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_spike
);

    localparam logic signed [POT_WIDTH:0]   WIDE_MAX = {2'b00, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [POT_WIDTH:0]   WIDE_MIN = {2'b11, {(POT_WIDTH-1){1'b0}}};
    localparam logic signed [POT_WIDTH-1:0] POT_ZERO = '0;

    logic signed [POT_WIDTH-1:0]  pot_q    [NUM_CH];
    logic signed [POT_WIDTH-1:0]  pot_d    [NUM_CH];
    logic [REFRAC_WIDTH-1:0]      refrac_q [NUM_CH];
    logic [REFRAC_WIDTH-1:0]      refrac_d [NUM_CH];
    logic                         out_valid_q, out_valid_d;
    logic [CH_W-1:0]              out_ch_q, out_ch_d;
    logic                         out_spike_q, out_spike_d;

    logic                         accept;
    logic signed [POT_WIDTH-1:0]  pot_cur;
    logic signed [POT_WIDTH:0]    pot_ext;
    logic signed [POT_WIDTH:0]    sum_ext;
    logic signed [POT_WIDTH:0]    sum_wide;
    logic signed [POT_WIDTH-1:0]  s_sat;
    logic signed [POT_WIDTH-1:0]  thr_ext;
    logic signed [POT_WIDTH-1:0]  idle_pot;
    logic                         fire;
`ifdef SPIKE_GEN_LEAK_EN
    logic signed [POT_WIDTH-1:0]  leak_ext;
    logic signed [POT_WIDTH-1:0]  leak_dn;
    logic signed [POT_WIDTH-1:0]  leak_up;
`endif

    assign in_ready = spike_en & ~clear_all;

    always_comb begin
        accept   = in_valid & in_ready;
        pot_cur  = pot_q[in_ch];
        pot_ext  = {pot_cur[POT_WIDTH-1], pot_cur};
        sum_ext  = {{(POT_WIDTH+1-SUM_WIDTH){in_sum[SUM_WIDTH-1]}}, in_sum};
        sum_wide = pot_ext + sum_ext;
        if (sum_wide > WIDE_MAX) begin
            s_sat = WIDE_MAX[POT_WIDTH-1:0];
        end else if (sum_wide < WIDE_MIN) begin
            s_sat = WIDE_MIN[POT_WIDTH-1:0];
        end else begin
            s_sat = sum_wide[POT_WIDTH-1:0];
        end
        thr_ext = {1'b0, threshold};
        fire    = (s_sat >= thr_ext);
`ifdef SPIKE_GEN_LEAK_EN
        // Leak moves toward zero and stops there; neither direction can overflow.
        leak_ext = {1'b0, leak};
        leak_dn  = s_sat - leak_ext;
        leak_up  = s_sat + leak_ext;
        if (s_sat > POT_ZERO) begin
            idle_pot = (leak_dn > POT_ZERO) ? leak_dn : POT_ZERO;
        end else if (s_sat < POT_ZERO) begin
            idle_pot = (leak_up < POT_ZERO) ? leak_up : POT_ZERO;
        end else begin
            idle_pot = POT_ZERO;
        end
`else
        idle_pot = s_sat;
`endif
    end

    always_comb begin
        pot_d       = pot_q;
        refrac_d    = refrac_q;
        out_valid_d = 1'b0;
        out_ch_d    = out_ch_q;
        out_spike_d = 1'b0;
        if (clear_all) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pot_d[i]    = '0;
                refrac_d[i] = '0;
            end
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_ch_d    = in_ch;
            if (refrac_q[in_ch] != '0) begin
                refrac_d[in_ch] = refrac_q[in_ch] - 1'b1;
            end else if (fire) begin
                out_spike_d     = 1'b1;
                refrac_d[in_ch] = refrac_period;
                pot_d[in_ch]    = reset_mode ? POT_ZERO : (s_sat - thr_ext);
            end else begin
                pot_d[in_ch]    = idle_pot;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pot_q[i]    <= '0;
                refrac_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_spike_q <= 1'b0;
        end else begin
            pot_q       <= pot_d;
            refrac_q    <= refrac_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_spike_q <= out_spike_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_spike = out_spike_q;

endmodule

// File: tb/tb_spike_gen_array.sv
// Directed bench for spike_gen_array; leak steps included when SPIKE_GEN_LEAK_EN is defined.
module tb_spike_gen_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        spike_en;
    logic        clear_all;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ch;
    logic [15:0] in_sum;
    logic [14:0] threshold;
    logic        reset_mode;
    logic [3:0]  refrac_period;
`ifdef SPIKE_GEN_LEAK_EN
    logic [14:0] leak;
`endif
    logic        out_valid;
    logic [1:0]  out_ch;
    logic        out_spike;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spike_gen_array dut (
        .clk(clk),
        .rst(rst),
        .spike_en(spike_en),
        .clear_all(clear_all),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_ch(in_ch),
        .in_sum(in_sum),
        .threshold(threshold),
        .reset_mode(reset_mode),
        .refrac_period(refrac_period),
`ifdef SPIKE_GEN_LEAK_EN
        .leak(leak),
`endif
        .out_valid(out_valid),
        .out_ch(out_ch),
        .out_spike(out_spike)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one input; it stays on the bus so consecutive calls are back-to-back.
    task automatic step(input string tag, input int ch, input int sum, input int exp_spike);
        logic [1:0]  ch_v;
        logic [15:0] sum_v;
        ch_v  = ch[1:0];
        sum_v = sum[15:0];
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = ch_v;
        in_sum   = sum_v;
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, int'(out_valid), 1);
        chk({tag, ".spike"}, int'(out_spike), exp_spike);
        chk({tag, ".ch"}, int'(out_ch), ch);
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".novalid"}, int'(out_valid), 0);
    endtask

    task automatic chk_pots(input string tag, input int p0, input int p1, input int p2, input int p3);
        chk({tag, ".pot0"}, int'(dut.pot_q[0]), p0);
        chk({tag, ".pot1"}, int'(dut.pot_q[1]), p1);
        chk({tag, ".pot2"}, int'(dut.pot_q[2]), p2);
        chk({tag, ".pot3"}, int'(dut.pot_q[3]), p3);
    endtask

    initial begin
        rst           = 1'b1;
        spike_en      = 1'b0;
        clear_all     = 1'b0;
        in_valid      = 1'b0;
        in_ch         = '0;
        in_sum        = '0;
        threshold     = '0;
        reset_mode    = 1'b0;
        refrac_period = '0;
`ifdef SPIKE_GEN_LEAK_EN
        leak          = '0;
`endif
        #3;
        chk("rst.valid", int'(out_valid), 0);
        chk("rst.spike", int'(out_spike), 0);
        chk("rst.ch", int'(out_ch), 0);
        chk_pots("rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        spike_en = 1'b1;
        #1;
        chk("rdy.en", int'(in_ready), 1);

        // Integrate then fire with subtract-reset: 60 -> 120-100 = 20.
        threshold = 15'd100;
        step("ch1a", 1, 60, 0);
        step("ch1b", 1, 60, 1);
        idle("ch1");
        chk_pots("ch1", 0, 20, 0, 0);

        // Reset-to-zero mode.
        reset_mode = 1'b1;
        threshold  = 15'd50;
        step("ch0", 0, 70, 1);
        idle("ch0");
        chk_pots("ch0", 0, 20, 0, 0);

        // Refractory: fire (pot 100), two ignored, then 300 fires -> 200.
        reset_mode    = 1'b0;
        threshold     = 15'd100;
        refrac_period = 4'd2;
        step("rf0", 2, 200, 1);
        step("rf1", 2, 200, 0);
        step("rf2", 2, 200, 0);
        step("rf3", 2, 200, 1);
        idle("rf");
        chk_pots("rf", 0, 20, 200, 0);
        chk("rf.refrac2", int'(dut.refrac_q[2]), 2);

        // Positive saturation: 32000+32000 clamps to 32767, fires exactly at threshold.
        refrac_period = 4'd0;
        threshold     = 15'd32767;
        step("satp0", 3, 32000, 0);
        step("satp1", 3, 32000, 1);
        idle("satp");
        chk_pots("satp", 0, 20, 200, 0);

        // Negative saturation holds at -32768.
        threshold = 15'd100;
        step("satn0", 0, -32768, 0);
        step("satn1", 0, -32768, 0);
        idle("satn");
        chk_pots("satn", -32768, 20, 200, 0);

        // Threshold zero: S = 0 fires.
        threshold = 15'd0;
        step("thr0", 3, 0, 1);
        idle("thr0");

        // clear_all beats a simultaneous input.
        threshold = 15'd100;
        @(negedge clk);
        in_valid  = 1'b1;
        in_ch     = 2'd1;
        in_sum    = 16'd5;
        clear_all = 1'b1;
        #1;
        chk("clr.rdy", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("clr.novalid", int'(out_valid), 0);
        chk_pots("clr", 0, 0, 0, 0);
        chk("clr.refrac2", int'(dut.refrac_q[2]), 0);
        @(negedge clk);
        clear_all = 1'b0;
        in_valid  = 1'b0;

        // spike_en low blocks input.
        spike_en = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("dis.rdy", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("dis.novalid", int'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        spike_en = 1'b1;

        // Reset mid-stream: result strobe suppressed, nothing after release.
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = 2'd2;
        in_sum   = 16'd150;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst.valid", int'(out_valid), 0);
        chk("mrst.spike", int'(out_spike), 0);
        chk_pots("mrst", 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst.novalid", int'(out_valid), 0);

`ifdef SPIKE_GEN_LEAK_EN
        // Leak: -3 with leak 5 stops at 0; 10 with leak 5 becomes 5.
        threshold = 15'd100;
        leak      = 15'd0;
        step("lk0", 0, -3, 0);
        leak = 15'd5;
        step("lk1", 0, 0, 0);
        step("lk2", 1, 10, 0);
        idle("lk");
        chk_pots("lk", 0, 5, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
